// File: rtl/fmult_rr_share_if.sv
// Bundle between the requester pipelines and the shared multiplier front end.
// FLEN comes from the project-wide `FLEN define (64 when not set elsewhere).
`ifndef FLEN
`define FLEN 64
`endif

// Request handshake: requester i is accepted in a cycle exactly when
// req_vld[i] & req_rdy[i]; req_rdy may depend on req_vld, never the reverse.
// Responses carry no ready: the requester must sink rsp_vld on the cycle it appears.
interface fmult_rr_share_if #(
   parameter int N_REQ = 4,
   parameter int CNT_W = 16
);
   localparam int FLEN = `FLEN;

   logic [N_REQ-1:0]       req_vld;
   logic [N_REQ*FLEN-1:0]  req_a;
   logic [N_REQ*FLEN-1:0]  req_b;
   logic [N_REQ-1:0]       req_rdy;
   logic [N_REQ-1:0]       rsp_vld;
   logic [FLEN-1:0]        rsp_res;
   logic                   rsp_err;
   logic                   align_err;
   logic [N_REQ*CNT_W-1:0] grant_cnt;

   modport master (
      output req_vld, req_a, req_b,
      input  req_rdy, rsp_vld, rsp_res, rsp_err, align_err, grant_cnt
   );

   modport slave (
      input  req_vld, req_a, req_b,
      output req_rdy, rsp_vld, rsp_res, rsp_err, align_err, grant_cnt
   );
endinterface

// File: rtl/fmult_rr_share.sv
// Round-robin front end sharing one pipelined f_mult among N_REQ requesters.
// Define FMULT_RR_SHARE_STATS_EN to build the per-requester saturating grant counters.
`ifndef FLEN
`define FLEN 64
`endif

module f_mult #(
   parameter int FLEN = 64,
   parameter int LAT  = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            up_valid,
   input  logic [FLEN-1:0] a,
   input  logic [FLEN-1:0] b,
   output logic            down_valid,
   output logic [FLEN-1:0] res,
   output logic            error
);
   localparam int EW = (FLEN == 32) ? 8 : 11;
   localparam int MW = FLEN - 1 - EW;
   localparam int PW = 2 * (MW + 1);
   localparam int XW = EW + 2;
   localparam logic        [XW-1:0] BIAS = XW'((1 << (EW - 1)) - 1);
   localparam logic signed [XW-1:0] EMAX = XW'((1 << EW) - 1);

   logic                   sa, sb, s;
   logic [EW-1:0]          ea, eb;
   logic [MW-1:0]          fa, fb;
   logic [PW-1:0]          prod, norm;
   logic [MW:0]            mant;
   logic                   guard, sticky, rnd;
   logic [MW+1:0]          mant_r;
   logic signed [XW-1:0]   exp_n, exp_r;
   logic [FLEN-1:0]        res_c;
   logic                   err_c;

   // Denormal inputs flush to zero; Inf/NaN inputs and out-of-range results raise error.
   always_comb begin
      sa     = a[FLEN-1];
      sb     = b[FLEN-1];
      ea     = a[FLEN-2 -: EW];
      eb     = b[FLEN-2 -: EW];
      fa     = a[MW-1:0];
      fb     = b[MW-1:0];
      s      = sa ^ sb;
      prod   = PW'({1'b1, fa}) * PW'({1'b1, fb});
      norm   = prod[PW-1] ? prod : (prod << 1);
      mant   = norm[PW-1 -: MW+1];
      guard  = norm[PW-MW-2];
      sticky = |norm[PW-MW-3:0];
      rnd    = guard & (sticky | mant[0]);
      mant_r = {1'b0, mant} + (MW+2)'(rnd);
      exp_n  = XW'(ea) + XW'(eb) - BIAS + XW'(prod[PW-1]);
      exp_r  = exp_n + XW'(mant_r[MW+1]);
      res_c  = {s, exp_r[EW-1:0], (mant_r[MW+1] ? mant_r[MW:1] : mant_r[MW-1:0])};
      err_c  = 1'b0;
      if (ea == '1 || eb == '1) begin
         err_c = 1'b1;
         res_c = {s, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
      end else if (ea == '0 || eb == '0) begin
         res_c = {s, {(FLEN-1){1'b0}}};
      end else if (exp_r >= EMAX) begin
         err_c = 1'b1;
         res_c = {s, {EW{1'b1}}, {MW{1'b0}}};
      end else if (exp_r <= 0) begin
         err_c = 1'b1;
         res_c = {s, {(FLEN-1){1'b0}}};
      end
   end

   logic [LAT-1:0]  vld_q;
   logic [LAT-1:0]  err_q;
   logic [FLEN-1:0] res_q [LAT];

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
         err_q <= '0;
         for (int i = 0; i < LAT; i++) res_q[i] <= '0;
      end else begin
         vld_q[0] <= up_valid;
         err_q[0] <= err_c;
         res_q[0] <= res_c;
         for (int i = 1; i < LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            err_q[i] <= err_q[i-1];
            res_q[i] <= res_q[i-1];
         end
      end
   end

   assign down_valid = vld_q[LAT-1];
   assign error      = err_q[LAT-1];
   assign res        = res_q[LAT-1];
endmodule

module fmult_rr_share #(
   parameter int N_REQ    = 4,
   parameter int MULT_LAT = 3,
   parameter int CNT_W    = 16
) (
   input logic               clk,
   input logic               rst,
   fmult_rr_share_if.slave   bus
);
   localparam int FLEN = `FLEN;
   localparam int IW   = $clog2(N_REQ);

   logic [IW-1:0]     ptr;
   logic [N_REQ-1:0]  grant;
   logic [IW-1:0]     gnt_idx;
   logic              found;
   int                j;

   // First requester at or after ptr, wrapping around.
   always_comb begin
      grant   = '0;
      gnt_idx = '0;
      found   = 1'b0;
      j       = 0;
      for (int off = 0; off < N_REQ; off++) begin
         j = (int'(ptr) + off) % N_REQ;
         if (!found && bus.req_vld[j]) begin
            found    = 1'b1;
            grant[j] = 1'b1;
            gnt_idx  = IW'(j);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) ptr <= '0;
      else if (found) ptr <= (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + IW'(1);
   end

   logic [FLEN-1:0] op_a, op_b, f_res;
   logic            f_vld, f_err;

   assign op_a = bus.req_a[gnt_idx*FLEN +: FLEN];
   assign op_b = bus.req_b[gnt_idx*FLEN +: FLEN];

   f_mult #(.FLEN(FLEN), .LAT(MULT_LAT)) u_mult (
      .clk        (clk),
      .rst        (rst),
      .up_valid   (found),
      .a          (op_a),
      .b          (op_b),
      .down_valid (f_vld),
      .res        (f_res),
      .error      (f_err)
   );

   // Requester index travels beside each op; never stalls, matching the multiplier.
   logic [MULT_LAT-1:0] tag_vld;
   logic [IW-1:0]       tag_idx [MULT_LAT];

   always_ff @(posedge clk) begin
      if (rst) begin
         tag_vld <= '0;
         for (int i = 0; i < MULT_LAT; i++) tag_idx[i] <= '0;
      end else begin
         tag_vld[0] <= found;
         tag_idx[0] <= gnt_idx;
         for (int i = 1; i < MULT_LAT; i++) begin
            tag_vld[i] <= tag_vld[i-1];
            tag_idx[i] <= tag_idx[i-1];
         end
      end
   end

   logic [N_REQ-1:0] rsp_vld_q;
   logic [FLEN-1:0]  rsp_res_q;
   logic             rsp_err_q;
   logic             align_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_vld_q <= '0;
         rsp_res_q <= '0;
         rsp_err_q <= 1'b0;
         align_q   <= 1'b0;
      end else begin
         rsp_vld_q <= f_vld ? (N_REQ'(1) << tag_idx[MULT_LAT-1]) : '0;
         rsp_res_q <= f_res;
         rsp_err_q <= f_err;
         if (f_vld != tag_vld[MULT_LAT-1]) align_q <= 1'b1;
      end
   end

   assign bus.req_rdy   = grant;
   assign bus.rsp_vld   = rsp_vld_q;
   assign bus.rsp_res   = rsp_res_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.align_err = align_q;

`ifdef FMULT_RR_SHARE_STATS_EN
   logic [CNT_W-1:0]       cnt_q [N_REQ];
   logic [N_REQ*CNT_W-1:0] cnt_flat;

   always_ff @(posedge clk) begin
      for (int i = 0; i < N_REQ; i++) begin
         if (rst) cnt_q[i] <= '0;
         else if (grant[i] && cnt_q[i] != '1) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
      end
   end

   always_comb begin
      cnt_flat = '0;
      for (int i = 0; i < N_REQ; i++) cnt_flat[i*CNT_W +: CNT_W] = cnt_q[i];
   end

   assign bus.grant_cnt = cnt_flat;
`else
   assign bus.grant_cnt = {(N_REQ*CNT_W){1'b0}};
`endif
endmodule
